mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single tagged memory port between the instruction-fetch requester (IF/icache
//  miss path) and the data requester (LSQ/dcache). Picks one request per cycle and records
//  the owner of each tag memory accepts. Sends each tagged load response back to its owner.
//  Drops in-flight fetch responses when a branch redirect squashes the fetch stream.
// PARAMETERS
//  TAG_W         4   width of memory tag; tag 0 = "not accepted / no response"
//  ADDR_W        64  request address width
//  STARVE_LIMIT  4   consecutive D grants allowed while I waits before I is forced
// PORTS
//  clock              in   1       system clock, all state on posedge
//  reset              in   1       asynchronous, ACTIVE-LOW reset
//  ic_req             in   1       fetch load request, held until ic_grant
//  ic_addr            in   ADDR_W  fetch address (8-byte aligned)
//  ic_grant           out  1       fetch request accepted by memory this cycle
//  ic_resp_valid      out  1       fetch data valid (registered)
//  ic_resp_data       out  64      fetch data
//  dc_req             in   1       data request, held until dc_grant
//  dc_cmd             in   2       1=LOAD 2=STORE (0 treated as no request)
//  dc_addr            in   ADDR_W  data address
//  dc_wdata           in   64      store data
//  dc_grant           out  1       data request accepted by memory this cycle
//  dc_resp_valid      out  1       load data valid (registered)
//  dc_resp_data       out  64      load data
//  fetch_squash       in   1       branch taken (ex_mem_take_branch0|1): kill fetch traffic
//  proc2mem_command   out  2       0=NONE 1=LOAD 2=STORE
//  proc2mem_addr      out  ADDR_W  request address
//  proc2mem_data      out  64      store data
//  mem2proc_response  in   TAG_W   tag for this cycle's request; 0 = rejected
//  mem2proc_data      in   64      returning load data
//  mem2proc_tag       in   TAG_W   tag of returning data; 0 = none
//  arb_tag_err        out  1       sticky: unknown response tag or tag reuse
// BEHAVIOUR
//  - Reset (reset==0, async): all outputs 0, tag table cleared, starve counter 0.
//  - Arbitration is combinational, one winner per cycle. D wins by default.
//    I wins if only ic_req is set, or if starve_cnt==STARVE_LIMIT and ic_req is set.
//  - I is not a candidate in a cycle with fetch_squash=1; ic_grant=0 that cycle.
//  - proc2mem_* driven from the winner; command NONE and addr/data 0 when no candidate.
//  - grant = winner & (mem2proc_response!=0), same cycle. On rejection nothing changes;
//    the requester keeps holding.
//  - Accepted LOAD: on posedge, tag_valid[resp]<=1, owner[resp]<=I/D, drop[resp]<=0.
//    Accepted STORE allocates no tag.
//  - Load to a tag that is already valid: the entry is overwritten and arb_tag_err is set.
//  - starve_cnt: +1 on each D grant while ic_req=1 (saturates at STARVE_LIMIT).
//    Cleared on I grant or when ic_req=0.
//  - Response with mem2proc_tag=t!=0 and tag_valid[t]: clear tag_valid[t] on posedge.
//    Next cycle the owner's resp_valid=1 with resp_data=mem2proc_data (latency 1),
//    unless owner=I and drop[t]=1.
//  - Response for a tag with tag_valid=0: ignored, arb_tag_err set.
//  - fetch_squash: on posedge, drop[t]<=1 for every valid I-owned tag. A response arriving
//    in the squash cycle for an I tag is also suppressed. D entries are untouched.
//  - A load accepted and answered with the same tag in the same cycle is illegal memory
//    behaviour; the response is routed using the table state before the update.
//  - resp_valid is a 1-cycle pulse; at most one response per cycle, so I and D are never
//    valid together.
//  - arb_tag_err is cleared only by reset.
// TESTING
//  1 reset low mid-traffic (3 tags valid) -> all outputs 0 next edge; tag 3 response after
//    release -> arb_tag_err=1, no resp_valid
//  2 ic_req=1, dc_req=0, addr=0x40, response=5 -> cmd=LOAD, ic_grant=1;
//    tag=5 data=0x0123456789abcdef -> ic_resp_valid=1 next cycle with that data
//  3 ic_req and dc_req(LOAD) held, memory accepts every cycle -> 4 D grants, then 1 I grant,
//    then D again
//  4 I load tag 2 outstanding, fetch_squash=1 -> tag-2 response gives no ic_resp_valid;
//    D load tag 3 in flight is delivered normally
//  5 dc STORE, response=0 for 2 cycles then 7 -> dc_grant only in 3rd cycle;
//    no tag allocated, later tag=7 response -> arb_tag_err=1
//  6 ic_req with fetch_squash=1 the same cycle -> ic_grant=0, cmd=NONE (dc_req=0);
//    granted the next cycle

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data, squash and memory-port signals of the memory port arbiter.
// master: the environment (requesters and memory); slave: the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned ADDR_W = 64
);
    // Fetch requester
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_grant;
    logic              ic_resp_valid;
    logic [63:0]       ic_resp_data;
    // Data requester
    logic              dc_req;
    logic [1:0]        dc_cmd;
    logic [ADDR_W-1:0] dc_addr;
    logic [63:0]       dc_wdata;
    logic              dc_grant;
    logic              dc_resp_valid;
    logic [63:0]       dc_resp_data;
    // Branch redirect
    logic              fetch_squash;
    // Memory port
    logic [1:0]        proc2mem_command;
    logic [ADDR_W-1:0] proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;
    // Status
    logic              arb_tag_err;

    modport master (
        output ic_req, ic_addr, dc_req, dc_cmd, dc_addr, dc_wdata, fetch_squash,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ic_grant, ic_resp_valid, ic_resp_data, dc_grant, dc_resp_valid, dc_resp_data,
               proc2mem_command, proc2mem_addr, proc2mem_data, arb_tag_err
    );

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_cmd, dc_addr, dc_wdata, fetch_squash,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output ic_grant, ic_resp_valid, ic_resp_data, dc_grant, dc_resp_valid, dc_resp_data,
               proc2mem_command, proc2mem_addr, proc2mem_data, arb_tag_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one tagged memory port between instruction fetch (I) and data (D) requesters.
// Tracks the owner of every outstanding load tag, routes responses back to their owner and
// discards fetch responses belonging to a squashed fetch stream.
module mem_port_arbiter #(
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned NumTags = 1 << TAG_W;
    localparam int unsigned CntW    = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] CmdNone  = 2'd0;
    localparam logic [1:0] CmdLoad  = 2'd1;

    // Tag table: one entry per tag value; entry 0 is never allocated.
    logic [NumTags-1:0] tag_valid_q, tag_valid_d;
    logic [NumTags-1:0] owner_i_q, owner_i_d;
    logic [NumTags-1:0] drop_q, drop_d;

    logic [CntW-1:0]    starve_q, starve_d;
    logic               err_q, err_d;
    logic               ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d;
    logic [63:0]        ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;

    logic               i_cand, d_cand, i_forced, win_i, win_d, mem_accepts;
    logic               ic_grant, dc_grant, load_accept;
    logic [1:0]         cmd;
    logic [ADDR_W-1:0]  addr;
    logic [63:0]        wdata;
    logic [TAG_W-1:0]   rtag, atag;

    assign rtag = bus.mem2proc_tag;
    assign atag = bus.mem2proc_response;

    // Arbitration and memory-port drive; candidates are gated by reset so every output is 0
    // while reset is held.
    always_comb begin
        i_cand      = reset & bus.ic_req & ~bus.fetch_squash;
        d_cand      = reset & bus.dc_req & (bus.dc_cmd != CmdNone);
        i_forced    = i_cand & (starve_q == CntW'(STARVE_LIMIT));
        win_d       = d_cand & ~i_forced;
        win_i       = i_cand & ~win_d;
        mem_accepts = (atag != '0);
        ic_grant    = win_i & mem_accepts;
        dc_grant    = win_d & mem_accepts;
        cmd         = CmdNone;
        addr        = '0;
        wdata       = '0;
        if (win_d) begin
            cmd   = bus.dc_cmd;
            addr  = bus.dc_addr;
            wdata = bus.dc_wdata;
        end else if (win_i) begin
            cmd   = CmdLoad;
            addr  = bus.ic_addr;
        end
        // Fetches are always loads; stores never occupy a tag.
        load_accept = ic_grant | (dc_grant & (bus.dc_cmd == CmdLoad));
    end

    // Next state: response routing, squash marking, tag allocation and starvation count.
    always_comb begin
        tag_valid_d = tag_valid_q;
        owner_i_d   = owner_i_q;
        drop_d      = drop_q;
        err_d       = err_q;
        starve_d    = starve_q;
        ic_rv_d     = 1'b0;
        dc_rv_d     = 1'b0;
        ic_rd_d     = ic_rd_q;
        dc_rd_d     = dc_rd_q;

        // Routing uses the table as it stood before this cycle's allocation.
        if (rtag != '0) begin
            if (tag_valid_q[rtag]) begin
                tag_valid_d[rtag] = 1'b0;
                if (!owner_i_q[rtag]) begin
                    dc_rv_d = 1'b1;
                    dc_rd_d = bus.mem2proc_data;
                end else if (!drop_q[rtag] && !bus.fetch_squash) begin
                    ic_rv_d = 1'b1;
                    ic_rd_d = bus.mem2proc_data;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (bus.fetch_squash) begin
            drop_d = drop_d | (tag_valid_q & owner_i_q);
        end

        if (load_accept) begin
            if (tag_valid_q[atag]) begin
                err_d = 1'b1;
            end
            tag_valid_d[atag] = 1'b1;
            owner_i_d[atag]   = win_i;
            drop_d[atag]      = 1'b0;
        end

        if (!bus.ic_req || ic_grant) begin
            starve_d = '0;
        end else if (dc_grant && (starve_q != CntW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= '0;
            owner_i_q   <= '0;
            drop_q      <= '0;
            starve_q    <= '0;
            err_q       <= 1'b0;
            ic_rv_q     <= 1'b0;
            dc_rv_q     <= 1'b0;
            ic_rd_q     <= '0;
            dc_rd_q     <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            owner_i_q   <= owner_i_d;
            drop_q      <= drop_d;
            starve_q    <= starve_d;
            err_q       <= err_d;
            ic_rv_q     <= ic_rv_d;
            dc_rv_q     <= dc_rv_d;
            ic_rd_q     <= ic_rd_d;
            dc_rd_q     <= dc_rd_d;
        end
    end

    assign bus.ic_grant         = ic_grant;
    assign bus.dc_grant         = dc_grant;
    assign bus.proc2mem_command = cmd;
    assign bus.proc2mem_addr    = addr;
    assign bus.proc2mem_data    = wdata;
    assign bus.ic_resp_valid    = ic_rv_q;
    assign bus.ic_resp_data     = ic_rd_q;
    assign bus.dc_resp_valid    = dc_rv_q;
    assign bus.dc_resp_data     = dc_rd_q;
    assign bus.arb_tag_err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked against a tag-table reference model.
module tb_mem_port_arbiter;

    localparam int unsigned TAG_W        = 4;
    localparam int unsigned ADDR_W       = 64;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int          NT           = 16;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    mem_port_arbiter_if #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .TAG_W       (TAG_W),
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: which tags are outstanding, who owns them, which are squashed.
    bit          m_valid[NT];
    bit          m_own_i[NT];
    bit          m_drop[NT];
    int          m_starve;
    bit          m_err;
    bit          e_ic_v, e_dc_v;
    logic [63:0] e_data;
    bit          m_ic_gnt, m_dc_gnt;
    logic        obs_ic_gnt, obs_dc_gnt;
    logic [1:0]  obs_cmd;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_valid[i] = 1'b0;
            m_own_i[i] = 1'b0;
            m_drop[i]  = 1'b0;
        end
        m_starve = 0;
        m_err    = 1'b0;
        e_ic_v   = 1'b0;
        e_dc_v   = 1'b0;
        m_ic_gnt = 1'b0;
        m_dc_gnt = 1'b0;
    endtask

    task automatic idle();
        bus.ic_req            = 1'b0;
        bus.ic_addr           = '0;
        bus.dc_req            = 1'b0;
        bus.dc_cmd            = CMD_NONE;
        bus.dc_addr           = '0;
        bus.dc_wdata          = '0;
        bus.fetch_squash      = 1'b0;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ic_grant"}, bus.ic_grant, 0);
        check_eq({tag, "_dc_grant"}, bus.dc_grant, 0);
        check_eq({tag, "_cmd"}, bus.proc2mem_command, 0);
        check_eq({tag, "_addr"}, bus.proc2mem_addr, 0);
        check_eq({tag, "_pdata"}, bus.proc2mem_data, 0);
        check_eq({tag, "_ic_rv"}, bus.ic_resp_valid, 0);
        check_eq({tag, "_ic_rd"}, bus.ic_resp_data, 0);
        check_eq({tag, "_dc_rv"}, bus.dc_resp_valid, 0);
        check_eq({tag, "_dc_rd"}, bus.dc_resp_data, 0);
        check_eq({tag, "_err"}, bus.arb_tag_err, 0);
    endtask

    // Hold reset for one edge, then release just after it.
    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        check_zero("rst");
        reset = 1'b1;
    endtask

    // One clock cycle: inputs were set just after the previous edge. Checks the same-cycle
    // outputs, advances the model, then checks the registered outputs after the edge.
    task automatic step();
        bit         ic_c, dc_c, win_i, win_d, acc, ld;
        bit         pre_valid[NT];
        logic [1:0] e_cmd;
        logic [63:0] e_addr;
        int         t, r;
        #2;
        ic_c  = bus.ic_req && !bus.fetch_squash;
        dc_c  = bus.dc_req && (bus.dc_cmd != CMD_NONE);
        win_d = dc_c && !(ic_c && (m_starve == STARVE_LIMIT));
        win_i = ic_c && !win_d;
        acc   = (bus.mem2proc_response != '0);
        e_cmd  = win_d ? bus.dc_cmd : (win_i ? CMD_LOAD : CMD_NONE);
        e_addr = win_d ? bus.dc_addr : (win_i ? bus.ic_addr : 64'd0);
        check_eq("ic_grant", bus.ic_grant, win_i && acc);
        check_eq("dc_grant", bus.dc_grant, win_d && acc);
        check_eq("cmd", bus.proc2mem_command, e_cmd);
        check_eq("addr", bus.proc2mem_addr, e_addr);
        if (!win_i && !win_d) check_eq("data_idle", bus.proc2mem_data, 0);
        else if (win_d && bus.dc_cmd == CMD_STORE) check_eq("store_data", bus.proc2mem_data,
                                                            bus.dc_wdata);
        obs_ic_gnt = bus.ic_grant;
        obs_dc_gnt = bus.dc_grant;
        obs_cmd    = bus.proc2mem_command;
        m_ic_gnt   = win_i && acc;
        m_dc_gnt   = win_d && acc;

        pre_valid = m_valid;
        e_ic_v    = 1'b0;
        e_dc_v    = 1'b0;
        t = int'(bus.mem2proc_tag);
        r = int'(bus.mem2proc_response);
        if (t != 0) begin
            if (pre_valid[t]) begin
                m_valid[t] = 1'b0;
                if (!m_own_i[t]) begin
                    e_dc_v = 1'b1;
                    e_data = bus.mem2proc_data;
                end else if (!m_drop[t] && !bus.fetch_squash) begin
                    e_ic_v = 1'b1;
                    e_data = bus.mem2proc_data;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (bus.fetch_squash) begin
            for (int i = 0; i < NT; i++) if (pre_valid[i] && m_own_i[i]) m_drop[i] = 1'b1;
        end
        ld = acc && (win_i || (win_d && bus.dc_cmd == CMD_LOAD));
        if (ld) begin
            if (pre_valid[r]) m_err = 1'b1;
            m_valid[r] = 1'b1;
            m_own_i[r] = win_i;
            m_drop[r]  = 1'b0;
        end
        if (!bus.ic_req || (win_i && acc)) m_starve = 0;
        else if (win_d && acc && m_starve < STARVE_LIMIT) m_starve++;

        @(posedge clock);
        #1;
        check_eq("ic_resp_valid", bus.ic_resp_valid, e_ic_v);
        check_eq("dc_resp_valid", bus.dc_resp_valid, e_dc_v);
        if (e_ic_v) check_eq("ic_resp_data", bus.ic_resp_data, e_data);
        if (e_dc_v) check_eq("dc_resp_data", bus.dc_resp_data, e_data);
        check_eq("arb_tag_err", bus.arb_tag_err, m_err);
    endtask

    initial begin
        idle();
        #1;
        do_reset();

        // Reset asserted mid-traffic with tags 1..3 outstanding.
        for (int k = 1; k <= 3; k++) begin
            bus.dc_req = 1'b1; bus.dc_cmd = CMD_LOAD; bus.dc_addr = 64'(k * 8);
            bus.mem2proc_response = TAG_W'(k);
            step();
        end
        bus.ic_req = 1'b1; bus.ic_addr = 64'h80; bus.mem2proc_response = 4'd4;
        reset = 1'b0;
        #1;
        check_zero("t1_async");
        @(posedge clock);
        #1;
        check_zero("t1_edge");
        model_reset();
        idle();
        reset = 1'b1;
        bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'hdead;
        step();
        check_eq("t1_err", bus.arb_tag_err, 1);
        check_eq("t1_no_dc_rv", bus.dc_resp_valid, 0);

        // Lone fetch request and its response.
        do_reset();
        bus.ic_req = 1'b1; bus.ic_addr = 64'h40; bus.mem2proc_response = 4'd5;
        step();
        check_eq("t2_ic_grant", obs_ic_gnt, 1);
        check_eq("t2_cmd", obs_cmd, CMD_LOAD);
        idle();
        bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 64'h0123456789abcdef;
        step();
        check_eq("t2_rv", bus.ic_resp_valid, 1);
        check_eq("t2_rd", bus.ic_resp_data, 64'h0123456789abcdef);

        // Starvation: four D grants, then I forced, then D again.
        do_reset();
        bus.ic_req = 1'b1; bus.ic_addr = 64'h100;
        bus.dc_req = 1'b1; bus.dc_cmd = CMD_LOAD; bus.dc_addr = 64'h200;
        for (int k = 0; k < 6; k++) begin
            bus.mem2proc_response = TAG_W'(k + 1);
            step();
            check_eq($sformatf("t3_dgnt%0d", k), obs_dc_gnt, (k != 4));
            check_eq($sformatf("t3_ignt%0d", k), obs_ic_gnt, (k == 4));
        end

        // Squash drops the outstanding fetch response but not the data one.
        do_reset();
        bus.ic_req = 1'b1; bus.ic_addr = 64'h48; bus.mem2proc_response = 4'd2;
        step();
        idle();
        bus.dc_req = 1'b1; bus.dc_cmd = CMD_LOAD; bus.dc_addr = 64'h300;
        bus.mem2proc_response = 4'd3;
        step();
        idle();
        bus.fetch_squash = 1'b1;
        step();
        idle();
        bus.mem2proc_tag = 4'd2; bus.mem2proc_data = 64'h1111;
        step();
        check_eq("t4_ic_dropped", bus.ic_resp_valid, 0);
        idle();
        bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'h2222;
        step();
        check_eq("t4_dc_rv", bus.dc_resp_valid, 1);
        check_eq("t4_dc_rd", bus.dc_resp_data, 64'h2222);
        check_eq("t4_err", bus.arb_tag_err, 0);

        // Store rejected twice, then accepted; no tag allocated.
        do_reset();
        bus.dc_req = 1'b1; bus.dc_cmd = CMD_STORE; bus.dc_addr = 64'h500;
        bus.dc_wdata = 64'hfeedbeef;
        for (int k = 0; k < 3; k++) begin
            bus.mem2proc_response = (k == 2) ? 4'd7 : 4'd0;
            step();
            check_eq($sformatf("t5_dgnt%0d", k), obs_dc_gnt, (k == 2));
        end
        idle();
        bus.mem2proc_tag = 4'd7;
        step();
        check_eq("t5_err", bus.arb_tag_err, 1);
        check_eq("t5_no_rv", bus.dc_resp_valid, 0);

        // Fetch request during squash waits one cycle.
        do_reset();
        bus.ic_req = 1'b1; bus.ic_addr = 64'h58; bus.fetch_squash = 1'b1;
        bus.mem2proc_response = 4'd4;
        step();
        check_eq("t6_no_grant", obs_ic_gnt, 0);
        check_eq("t6_cmd_none", obs_cmd, CMD_NONE);
        bus.fetch_squash = 1'b0;
        step();
        check_eq("t6_grant", obs_ic_gnt, 1);

        // Random traffic with a legal memory model.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int free_q[$];
            int busy_q[$];
            if (!bus.ic_req || m_ic_gnt) begin
                bus.ic_req  = ($urandom_range(0, 99) < 60);
                bus.ic_addr = {$urandom, $urandom} & ~64'h7;
            end
            if (!bus.dc_req || m_dc_gnt || bus.dc_cmd == CMD_NONE) begin
                bus.dc_req   = ($urandom_range(0, 99) < 60);
                bus.dc_cmd   = ($urandom_range(0, 9) == 0) ? CMD_NONE :
                               (($urandom_range(0, 2) == 0) ? CMD_STORE : CMD_LOAD);
                bus.dc_addr  = {$urandom, $urandom};
                bus.dc_wdata = {$urandom, $urandom};
            end
            bus.fetch_squash = ($urandom_range(0, 9) == 0);
            for (int i = 1; i < NT; i++) begin
                if (m_valid[i]) busy_q.push_back(i);
                else free_q.push_back(i);
            end
            bus.mem2proc_response = '0;
            if (free_q.size() > 0 && $urandom_range(0, 99) < 70)
                bus.mem2proc_response = TAG_W'(free_q[$urandom_range(0, free_q.size() - 1)]);
            bus.mem2proc_tag  = '0;
            bus.mem2proc_data = {$urandom, $urandom};
            if (busy_q.size() > 0 && $urandom_range(0, 99) < 40)
                bus.mem2proc_tag = TAG_W'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
